unit_a_seq: RTL and testbench
=============================

UNIT_A_SEQ -- requirements
Module: unit_a_seq

Interface
REQ-001 Parameter EXEC_CYCLES, default 2: settle cycles between launching operands into unit_A and capturing its outputs (legal 1..15).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_a  input  32  operand a.
REQ-007 req_b  input  32  operand b.
REQ-008 req_op  input  2  function code forwarded to unit_A f[1:0] (00 ADD, 01 SUB).
REQ-009 rsp_valid  output  1  response held.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_s  output  32  captured result.
REQ-012 rsp_flags  output  4  {N,Z,C,V} of captured result.
REQ-013 sticky_v  output  1  set by any captured V=1 since last clear.
REQ-014 clr_sticky  input  1  synchronous clear of sticky_v.
REQ-015 op_count  output  16  number of completed responses (handshaken), wraps.

Function
REQ-016 Request handshake completes on a rising edge with req_valid=1 and req_ready=1; response handshake completes with rsp_valid=1 and rsp_ready=1.
REQ-017 FSM states IDLE, EXEC, HOLD; req_ready=1 only in IDLE.
REQ-018 IDLE -> EXEC on request handshake; a, b, op latched into operand registers that drive unit_A; settle counter loaded with EXEC_CYCLES-1.
REQ-019 EXEC: counter decrements each cycle; at counter 0, s, c_out, O captured and state -> HOLD with rsp_valid=1 the next cycle.
REQ-020 Latency: rsp_valid rises exactly EXEC_CYCLES+1 cycles after the request handshake edge.
REQ-021 Flags: N=s[31], Z=(s==0), C=unit_A c_out, V=unit_A O; all from the same capture edge.
REQ-022 HOLD: rsp_s, rsp_flags stable while rsp_valid=1 and rsp_ready=0; HOLD -> IDLE on response handshake.
REQ-023 No same-cycle pass-through: a new request is accepted no earlier than the cycle after the response handshake.
REQ-024 Operand registers unchanged outside the IDLE accept edge; req_* ignored while req_ready=0.
REQ-025 sticky_v set on capture edge when V=1; clr_sticky=1 clears it; clear and set on same edge -> set wins.
REQ-026 op_count increments on each response handshake; 16'hFFFF wraps to 0.

Reset
REQ-027 rst_n low asynchronously forces IDLE, req_ready=1 after release, rsp_valid=0, rsp_s=0, rsp_flags=0, sticky_v=0, op_count=0, operand registers 0, counter 0.
REQ-028 Reset during EXEC or HOLD discards the in-flight operation; no response produced.

Structure
REQ-029 Shared package: op code constants (ADD=2'b00, SUB=2'b01), flag bit positions (N=3,Z=2,C=1,V=0), FSM state encodings.
REQ-030 Exactly one sub-module: unit_A, instantiated unchanged, fed only from operand registers.

Verification
REQ-031 a=7FFFFFFF, b=00000001, op=ADD, EXEC_CYCLES=2 -> rsp_valid at handshake+3, rsp_s=80000000, flags N=1,Z=0,C=0,V=1, sticky_v=1.
REQ-032 a=7FFFFFFF, b=00000001, op=SUB -> rsp_s=7FFFFFFE, V=0, Z=0, N=0; then b=FFFFFFFF, op=SUB -> rsp_s=80000000, V=1.
REQ-033 a=00000001, b=00000001, op=SUB -> rsp_s=0, Z=1, V=0.
REQ-034 rsp_ready held 0 for 5 cycles -> rsp_s/flags stable, req_ready=0 throughout; release -> op_count +1, req_ready=1 next cycle.
REQ-035 rst_n pulsed low mid-EXEC -> all outputs zero immediately, no rsp_valid afterwards; clr_sticky coincident with V=1 capture -> sticky_v=1.
REQ-036 op_count preset via 65535 handshakes -> next response makes op_count=0.

Source files
------------

// File: rtl/unit_a_seq_pkg.sv
// Shared definitions for unit_a_seq: function codes, flag bit positions, FSM states.
package unit_a_seq_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   function automatic logic [3:0] make_flags(input logic [31:0] s, input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_N] = s[31];
      f[FLAG_Z] = (s == '0);
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/unit_a_seq_unit_a.sv
// Combinational ALU core. For SUB, c_out is the carry of a + ~b + 1 (1 = no borrow);
// O is two's-complement overflow for ADD/SUB, and is 0 for the logic ops.
module unit_A
   import unit_a_seq_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  f,
   output logic [31:0] s,
   output logic        c_out,
   output logic        O
);

   logic [32:0] sum;

   always_comb begin
      sum   = '0;
      s     = '0;
      c_out = 1'b0;
      O     = 1'b0;
      case (f)
         OP_ADD: begin
            sum   = {1'b0, a} + {1'b0, b};
            s     = sum[31:0];
            c_out = sum[32];
            O     = (a[31] == b[31]) && (s[31] != a[31]);
         end
         OP_SUB: begin
            sum   = {1'b0, a} + {1'b0, ~b} + 33'd1;
            s     = sum[31:0];
            c_out = sum[32];
            O     = (a[31] != b[31]) && (s[31] != a[31]);
         end
         OP_AND:  s = a & b;
         default: s = a | b;
      endcase
   end

endmodule

// File: rtl/unit_a_seq.sv
// Sequencer around unit_A: accept one request, let unit_A settle EXEC_CYCLES cycles,
// capture result + flags, and hold the response until the consumer takes it.
module unit_a_seq
   import unit_a_seq_pkg::*;
#(
   parameter int EXEC_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [1:0]  req_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_s,
   output logic [3:0]  rsp_flags,
   output logic        sticky_v,
   input  logic        clr_sticky,
   output logic [15:0] op_count
);

   localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

   state_e      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic [1:0]  op_q, op_d;
   logic [3:0]  cnt_q, cnt_d, flags_q, flags_d;
   logic        sticky_q, sticky_d, capture;
   logic [15:0] op_count_q, op_count_d;

   logic [31:0] alu_s;
   logic        alu_c, alu_o;

   unit_A u_alu (
      .a     (a_q),
      .b     (b_q),
      .f     (op_q),
      .s     (alu_s),
      .c_out (alu_c),
      .O     (alu_o)
   );

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      s_d        = s_q;
      flags_d    = flags_q;
      op_count_d = op_count_q;
      capture    = 1'b0;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = ST_EXEC;
               a_d     = req_a;
               b_d     = req_b;
               op_d    = req_op;
               cnt_d   = CNT_INIT;
            end
         end
         ST_EXEC: begin
            if (cnt_q == 4'd0) begin
               capture = 1'b1;
               s_d     = alu_s;
               flags_d = make_flags(alu_s, alu_c, alu_o);
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d    = ST_IDLE;
               op_count_d = op_count_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A V=1 capture overrides a coincident clear.
      sticky_d = (sticky_q & ~clr_sticky) | (capture & alu_o);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         cnt_q      <= '0;
         s_q        <= '0;
         flags_q    <= '0;
         sticky_q   <= 1'b0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         s_q        <= s_d;
         flags_q    <= flags_d;
         sticky_q   <= sticky_d;
         op_count_q <= op_count_d;
      end
   end

   assign rsp_s     = s_q;
   assign rsp_flags = flags_q;
   assign sticky_v  = sticky_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_unit_a_seq.sv
// Bench for unit_a_seq: directed vector table, reset/sticky/wrap sequences, random ops vs reference model.
module tb_unit_a_seq;
   import unit_a_seq_pkg::*;

   localparam int EC = 2;
   localparam longint S_MAX = 64'sd2147483647;
   localparam longint S_MIN = -64'sd2147483648;
   localparam longint U_MAX = 64'sd4294967295;

   logic        clk = 1'b0;
   logic        rst_n, req_valid, rsp_ready, clr_sticky;
   logic        req_ready, rsp_valid, sticky_v;
   logic [31:0] req_a, req_b, rsp_s;
   logic [1:0]  req_op;
   logic [3:0]  rsp_flags;
   logic [15:0] op_count;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] exp_count = '0;
   logic        sticky_m = 1'b0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      bit          clr;
      int          hold;
      logic [31:0] s;
      logic [3:0]  f;
      logic        sticky;
   } vec_t;

   vec_t tbl[7];

   unit_a_seq #(.EXEC_CYCLES(EC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_s      (rsp_s),
      .rsp_flags  (rsp_flags),
      .sticky_v   (sticky_v),
      .clr_sticky (clr_sticky),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: {N,Z,C,V, s} from signed/unsigned integer arithmetic.
   function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      longint sa, sb, ua, ub, res;
      logic [31:0] s;
      logic c, v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      c  = 1'b0;
      case (op)
         OP_ADD: begin res = sa + sb; c = (ua + ub) > U_MAX; end
         OP_SUB: begin res = sa - sb; c = (ua >= ub); end
         OP_AND: res = longint'($signed(a & b));
         default: res = longint'($signed(a | b));
      endcase
      s = res[31:0];
      v = (res > S_MAX) || (res < S_MIN);
      return {s[31], s == 32'd0, c, v, s};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sticky();
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
   endtask

   // Entered and left 1 time unit after a rising edge with the DUT idle.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input int hold, input bit clr_cap,
                         input logic [31:0] exp_s, input logic [3:0] exp_f, input logic exp_st);
      int k;
      check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_op    = op;
      tick();
      // Garbage on the request bus must be ignored until the response completes.
      req_a  = $urandom;
      req_b  = $urandom;
      req_op = 2'($urandom_range(0, 3));
      check({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
      k = 0;
      while (!rsp_valid && k < 40) begin
         if (clr_cap && k == EC - 1) clr_sticky = 1'b1;
         tick();
         clr_sticky = 1'b0;
         k++;
      end
      // Latency = rising edges from request handshake to the first edge seeing rsp_valid=1.
      check({tag, " latency"}, 32'(k + 1), 32'(EC + 1));
      if (!rsp_valid) begin
         req_valid = 1'b0;
         return;
      end
      check({tag, " rsp_s"}, rsp_s, exp_s);
      check({tag, " rsp_flags"}, 32'(rsp_flags), 32'(exp_f));
      check({tag, " sticky_v"}, 32'(sticky_v), 32'(exp_st));
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
         check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
         check({tag, " hold rsp_s"}, rsp_s, exp_s);
         check({tag, " hold rsp_flags"}, 32'(rsp_flags), 32'(exp_f));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_count = exp_count + 16'd1;
      check({tag, " rsp_valid after"}, 32'(rsp_valid), 32'd0);
      check({tag, " req_ready after"}, 32'(req_ready), 32'd1);
      check({tag, " op_count"}, 32'(op_count), 32'(exp_count));
   endtask

   initial begin
      logic [35:0] m;
      logic [31:0] ra, rb;
      logic [1:0]  rop;
      bit          rclr, rcap;
      bit          saw_rsp;

      tbl[0] = '{32'h7FFFFFFF, 32'h00000001, OP_ADD, 1'b0, 5, 32'h80000000, 4'b1001, 1'b1};
      tbl[1] = '{32'h7FFFFFFF, 32'h00000001, OP_SUB, 1'b1, 0, 32'h7FFFFFFE, 4'b0010, 1'b0};
      tbl[2] = '{32'h7FFFFFFF, 32'hFFFFFFFF, OP_SUB, 1'b0, 1, 32'h80000000, 4'b1001, 1'b1};
      tbl[3] = '{32'h00000001, 32'h00000001, OP_SUB, 1'b1, 0, 32'h00000000, 4'b0110, 1'b0};
      tbl[4] = '{32'h00000000, 32'h00000000, OP_ADD, 1'b0, 2, 32'h00000000, 4'b0100, 1'b0};
      tbl[5] = '{32'hFFFFFFFF, 32'h00000001, OP_ADD, 1'b0, 0, 32'h00000000, 4'b0110, 1'b0};
      tbl[6] = '{32'h80000000, 32'h00000001, OP_SUB, 1'b0, 0, 32'h7FFFFFFF, 4'b0011, 1'b1};

      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; clr_sticky = 1'b0;
      req_a = '0; req_b = '0; req_op = '0;
      #2;
      check("reset req_ready", 32'(req_ready), 32'd1);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_s", rsp_s, 32'd0);
      check("reset rsp_flags", 32'(rsp_flags), 32'd0);
      check("reset sticky_v", 32'(sticky_v), 32'd0);
      check("reset op_count", 32'(op_count), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         if (tbl[i].clr) clear_sticky();
         run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].hold, 1'b0,
                tbl[i].s, tbl[i].f, tbl[i].sticky);
      end

      // Asynchronous reset while the operation is still settling.
      req_valid = 1'b1; req_a = 32'h7FFFFFFF; req_b = 32'h1; req_op = OP_ADD;
      tick();
      req_valid = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("midexec rsp_valid", 32'(rsp_valid), 32'd0);
      check("midexec rsp_s", rsp_s, 32'd0);
      check("midexec rsp_flags", 32'(rsp_flags), 32'd0);
      check("midexec sticky_v", 32'(sticky_v), 32'd0);
      check("midexec op_count", 32'(op_count), 32'd0);
      tick();
      rst_n = 1'b1;
      exp_count = '0;
      sticky_m = 1'b0;
      saw_rsp = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rsp_valid) saw_rsp = 1'b1;
      end
      check("post-reset no rsp", 32'(saw_rsp), 32'd0);
      check("post-reset req_ready", 32'(req_ready), 32'd1);

      // Clear coincident with a V=1 capture: the set wins.
      check("pre-capclr sticky_v", 32'(sticky_v), 32'd0);
      run_op("capclr", 32'h7FFFFFFF, 32'h1, OP_ADD, 0, 1'b1, 32'h80000000, 4'b1001, 1'b1);
      sticky_m = 1'b1;

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0: ra = 32'h7FFFFFFF;
            1: ra = 32'h80000000;
            2: ra = 32'hFFFFFFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0: rb = 32'h00000001;
            1: rb = ra;
            2: rb = 32'h80000000;
            default: rb = $urandom;
         endcase
         rop  = 2'($urandom_range(0, 3));
         rclr = ($urandom_range(0, 3) == 0);
         rcap = ($urandom_range(0, 3) == 0);
         if (rclr) begin
            clear_sticky();
            sticky_m = 1'b0;
         end
         m = model(ra, rb, rop);
         if (rcap) sticky_m = m[32];
         else      sticky_m = sticky_m | m[32];
         run_op($sformatf("rnd%0d", i), ra, rb, rop, $urandom_range(0, 3), rcap,
                m[31:0], m[35:32], sticky_m);
      end

      // op_count wrap: preset to FFFF, then one more response.
      force dut.op_count_q = 16'hFFFF;
      #1;
      release dut.op_count_q;
      tick();
      check("wrap preset", 32'(op_count), 32'h0000FFFF);
      exp_count = 16'hFFFF;
      m = model(32'd5, 32'd3, OP_SUB);
      run_op("wrap", 32'd5, 32'd3, OP_SUB, 0, 1'b0, m[31:0], m[35:32], sticky_m | m[32]);
      check("wrap op_count zero", 32'(op_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
